// File: rtl/blur_mem_sequencer_if.sv
// rtl/blur_mem_sequencer_if.sv - pixel memory bus between the blur sequencer and the single-port memory
interface blur_mem_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mem_trigger;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Sequencer side: drives the memory pins, consumes registered read data.
  modport master (
    output mem_trigger,
    output mem_address,
    output mem_din,
    input  mem_dout
  );

  // Memory side.
  modport slave (
    input  mem_trigger,
    input  mem_address,
    input  mem_din,
    output mem_dout
  );
endinterface

// File: rtl/blur_mem_sequencer.sv
// rtl/blur_mem_sequencer.sv - in-place [1 2 1]/4 blur pass over a single-port pixel memory
module blur_mem_sequencer #(
  parameter int DEPTH  = 26,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  blur_mem_sequencer_if.master mem
);

  localparam int SUM_W = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    LAT0,
    READ,
    LATCH,
    WRITE,
    DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] prev_q, cur_q, next_q;
  logic              busy_q, done_q, trig_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [SUM_W-1:0]  sum_d;
  logic [DATA_W-1:0] blur_d;

  // Read address for the right neighbour of idx; the last word re-reads itself
  // so the right edge is replicated.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] idx);
    return (idx == LAST) ? idx : idx + ADDR_W'(1);
  endfunction

  // Rounded blur of the window, with the right neighbour taken straight from
  // the memory read port as it is captured; the sum is wide enough never to wrap.
  always_comb begin
    sum_d  = {2'b00, prev_q} + {1'b0, cur_q, 1'b0} + {2'b00, mem.mem_dout} + SUM_W'(2);
    blur_d = DATA_W'(sum_d >> 2);
  end

  // Pass sequencer: window shifting, index and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          trig_q <= 1'b0;
          addr_q <= '0;
          if (start) begin
            state_q <= RD0;
            busy_q  <= 1'b1;
          end
        end
        RD0: begin
          state_q <= LAT0;
        end
        LAT0: begin
          // Left edge: the first word stands in for its missing left neighbour.
          prev_q  <= mem.mem_dout;
          cur_q   <= mem.mem_dout;
          idx_q   <= '0;
          addr_q  <= rd_addr('0);
          state_q <= READ;
        end
        READ: begin
          state_q <= LATCH;
        end
        LATCH: begin
          next_q  <= mem.mem_dout;
          din_q   <= blur_d;
          trig_q  <= 1'b1;
          addr_q  <= idx_q;
          state_q <= WRITE;
        end
        WRITE: begin
          // Original neighbours survive in the window even though idx is now overwritten.
          trig_q <= 1'b0;
          prev_q <= cur_q;
          cur_q  <= next_q;
          if (idx_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= '0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            addr_q  <= rd_addr(idx_q + ADDR_W'(1));
            state_q <= READ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          trig_q  <= 1'b0;
          addr_q  <= '0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem.mem_trigger = trig_q;
  assign mem.mem_address = addr_q;
  assign mem.mem_din     = din_q;

endmodule

// File: tb/tb_blur_mem_sequencer.sv
// tb/tb_blur_mem_sequencer.sv - self-checking bench for blur_mem_sequencer against a blur reference model
module tb_blur_mem_sequencer;
  localparam int DEPTH  = 26;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PASS_CYCLES = 2 + 3 * DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  blur_mem_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  blur_mem_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: single port, registered read data, bulk preload from img.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] img   [DEPTH];
  logic [DATA_W-1:0] dout_q = '0;
  logic              load_req = 1'b0;
  assign bus.mem_dout = dout_q;

  always @(posedge clk) begin
    if (load_req) mem_q <= img;
    else if (int'(bus.mem_address) < DEPTH) begin
      if (bus.mem_trigger) mem_q[bus.mem_address] <= bus.mem_din;
      else dout_q <= mem_q[bus.mem_address];
    end
  end

  int errors = 0;
  int checks = 0;
  int busy_cycles, done_cnt, done_misplaced;
  int wr_addr [$];
  logic [DATA_W-1:0] wr_data [$];
  logic prev_busy = 1'b0;

  // Bus monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) prev_busy = 1'b0;
    else begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (!(prev_busy && !busy)) done_misplaced++;
      end
      if (bus.mem_trigger) begin
        wr_addr.push_back(int'(bus.mem_address));
        wr_data.push_back(bus.mem_din);
      end
      prev_busy = busy;
    end
  end

  task automatic clear_logs();
    busy_cycles = 0;
    done_cnt = 0;
    done_misplaced = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic load_img();
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Runs one pass from the current memory contents and checks it against the model.
  task automatic run_pass(input string name, input bit restart_mid);
    logic [DATA_W-1:0] orig [DEPTH];
    logic [DATA_W-1:0] expv [DEPTH];
    longint l, c, r;
    int wait_cyc;
    for (int k = 0; k < DEPTH; k++) orig[k] = mem_q[k];
    for (int k = 0; k < DEPTH; k++) begin
      l = longint'(orig[(k == 0) ? 0 : k - 1]);
      c = longint'(orig[k]);
      r = longint'(orig[(k == DEPTH - 1) ? k : k + 1]);
      expv[k] = DATA_W'((l + 2 * c + r + 2) / 4);
    end
    @(posedge clk); #1;
    clear_logs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (restart_mid) begin
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_cyc = 0;
    while (done_cnt == 0 && wait_cyc < 300) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, wait_cyc);
    end
    checks++;
    if (busy_cycles !== PASS_CYCLES) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, PASS_CYCLES);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_misplaced !== 0) begin
      errors++;
      $display("FAIL %s done_timing: %0d pulses not right after busy fell", name, done_misplaced);
    end
    checks++;
    if (wr_addr.size() !== DEPTH) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH && k < wr_addr.size(); k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== expv[k]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %0d data %0h expected addr %0d data %0h",
                 name, k, wr_addr[k], wr_data[k], k, expv[k]);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (mem_q[k] !== expv[k]) begin
        errors++;
        $display("FAIL %s final_word[%0d]: got %0h expected %0h", name, k, mem_q[k], expv[k]);
      end
    end
  endtask

  task automatic expect_word(input string name, input int k, input logic [DATA_W-1:0] v);
    checks++;
    if (mem_q[k] !== v) begin
      errors++;
      $display("FAIL %s word[%0d]: got %0h expected %0h", name, k, mem_q[k], v);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_trigger !== 1'b0 ||
        bus.mem_address !== '0 || bus.mem_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b trig=%b addr=%0d din=%0h expected all 0",
               busy, done, bus.mem_trigger, bus.mem_address, bus.mem_din);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_uniform();
    for (int k = 0; k < DEPTH; k++) img[k] = 32'd100;
    load_img();
    run_pass("uniform", 1'b0);
  endtask

  task automatic test_impulse();
    for (int k = 0; k < DEPTH; k++) img[k] = '0;
    img[5] = 32'd400;
    load_img();
    run_pass("impulse", 1'b0);
    expect_word("impulse", 4, 32'd100);
    expect_word("impulse", 5, 32'd200);
    expect_word("impulse", 6, 32'd100);
    expect_word("impulse", 7, 32'd0);
  endtask

  task automatic test_edges();
    for (int k = 0; k < DEPTH; k++) img[k] = '0;
    img[0] = 32'd1;
    load_img();
    run_pass("left_edge", 1'b0);
    expect_word("left_edge", 0, 32'd1);
    expect_word("left_edge", 1, 32'd0);
    for (int k = 0; k < DEPTH; k++) img[k] = DATA_W'(4 * k);
    load_img();
    run_pass("ramp", 1'b0);
    expect_word("ramp", 0, 32'd1);
    expect_word("ramp", DEPTH - 1, 32'd99);
    expect_word("ramp", 12, 32'd48);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < DEPTH; k++) img[k] = 32'hFFFF_FFFF;
    load_img();
    run_pass("overflow", 1'b0);
    expect_word("overflow", 13, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < DEPTH; k++)
        img[k] = (n == 2) ? DATA_W'($urandom_range(0, 1000)) : DATA_W'($urandom);
      load_img();
      run_pass("random", 1'b0);
    end
  endtask

  task automatic test_back_to_back_start();
    for (int k = 0; k < DEPTH; k++) img[k] = DATA_W'($urandom);
    load_img();
    run_pass("restart_ignored", 1'b1);
  endtask

  task automatic test_reset_mid_pass();
    int quiet_busy;
    for (int k = 0; k < DEPTH; k++) img[k] = DATA_W'($urandom);
    load_img();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.mem_address !== '0) begin
      errors++;
      $display("FAIL reset_mid_pass: got trig=%b busy=%b done=%b addr=%0d expected 0 0 0 0",
               bus.mem_trigger, busy, done, bus.mem_address);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    repeat (5) @(posedge clk);
    #1;
    quiet_busy = busy_cycles;
    checks++;
    if (done_cnt !== 0 || quiet_busy !== 0 || wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL after_reset_idle: got done=%0d busy_cycles=%0d writes=%0d expected 0 0 0",
               done_cnt, quiet_busy, wr_addr.size());
    end
    run_pass("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_impulse();
    test_edges();
    test_overflow();
    test_random();
    test_back_to_back_start();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
